// File: rtl/example_decimator.sv
`default_nettype none
// ============================================================================
// Module      : example_decimator
// Description : Averaging decimator. Accumulates 2^L strobed signed samples
//               and emits their mean with a one-cycle ce_out strobe. L is
//               requested on log2_rate, clamped to ML, and latched at the
//               first sample of every block so mid-block changes are ignored.
// Ports       : clk       - system clock, rising edge
//               rst_n     - asynchronous active-low reset
//               ce_in     - input sample strobe
//               sig_in    - signed input sample (DW bits)
//               log2_rate - requested log2 decimation ratio
//               clr       - synchronous block restart (wins over ce_in)
//               ce_out    - one-cycle output strobe
//               sig_out   - signed mean, held between strobes
// Options     : ROUND_EN - when defined, the mean is rounded half-up;
//                          otherwise it is truncated toward -inf.
// Revision    : 1.0 - initial release
// ============================================================================
module example_decimator #(
    parameter int DW = 16,
    parameter int ML = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ce_in,
    input  logic [DW-1:0] sig_in,
    input  logic [3:0]    log2_rate,
    input  logic          clr,
    output logic          ce_out,
    output logic [DW-1:0] sig_out
);

    localparam int          c_aw  = DW + ML;
    localparam logic [3:0]  c_ml4 = 4'(ML);

    logic signed [c_aw-1:0] r_acc;
    logic        [ML-1:0]   r_cnt;
    logic        [3:0]      r_lat_l;
    logic                   r_ce_out;
    logic        [DW-1:0]   r_sig_out;

    logic        [3:0]      w_clamp;
    logic        [3:0]      w_l_eff;
    logic        [ML:0]     w_mask;
    logic                   w_last;
    logic signed [c_aw-1:0] w_sext;
    logic signed [c_aw-1:0] w_sum;
    logic signed [c_aw-1:0] w_pre;
    logic        [DW-1:0]   w_mean;

    // The ratio seen by the first sample of a block is the freshly clamped
    // request; every later sample uses the value latched by that first one.
    assign w_clamp = (log2_rate > c_ml4) ? c_ml4 : log2_rate;
    assign w_l_eff = (r_cnt == '0) ? w_clamp : r_lat_l;

    // Last sample of the block when cnt reaches 2^L - 1. One extra bit keeps
    // 2^ML representable for the largest ratio.
    assign w_mask  = ((ML+1)'(1) << w_l_eff) - (ML+1)'(1);
    assign w_last  = ({1'b0, r_cnt} == w_mask);

    assign w_sext  = {{ML{sig_in[DW-1]}}, sig_in};
    assign w_sum   = r_acc + w_sext;

`ifdef ROUND_EN
    // Half-up rounding: add half an LSB of the result before the shift.
    // L = 0 adds nothing so pass-through is exact.
    logic signed [c_aw-1:0] w_rnd;
    assign w_rnd   = (w_l_eff == 4'd0) ? '0 : (c_aw'(1) << (w_l_eff - 4'd1));
    assign w_pre   = w_sum + w_rnd;
`else
    assign w_pre   = w_sum;
`endif

    // Arithmetic shift gives the floor of the (possibly biased) mean; the
    // result always fits DW bits, so the upper bits are simply dropped.
    assign w_mean  = DW'(w_pre >>> w_l_eff);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_lat_l   <= '0;
            r_ce_out  <= 1'b0;
            r_sig_out <= '0;
        end else begin
            r_ce_out <= 1'b0;
            if (clr) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else if (ce_in) begin
                if (r_cnt == '0) begin
                    r_lat_l <= w_clamp;
                end
                if (w_last) begin
                    r_sig_out <= w_mean;
                    r_ce_out  <= 1'b1;
                    r_acc     <= '0;
                    r_cnt     <= '0;
                end else begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign ce_out  = r_ce_out;
    assign sig_out = r_sig_out;

endmodule
`default_nettype wire

// File: tb/tb_example_decimator.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_example_decimator
// Description : Self-checking bench for example_decimator. Expected means are
//               queued when a block's last sample is driven and popped when
//               ce_out fires; ce_out must fire exactly one clock later and
//               sig_out must hold its last value otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_example_decimator;

    localparam int DW = 16;
    localparam int ML = 8;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          ce_in     = 1'b0;
    logic [DW-1:0] sig_in    = '0;
    logic [3:0]    log2_rate = '0;
    logic          clr       = 1'b0;
    logic          ce_out;
    logic [DW-1:0] sig_out;

    always #5 clk = ~clk;

    example_decimator #(.DW(DW), .ML(ML)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ce_in     (ce_in),
        .sig_in    (sig_in),
        .log2_rate (log2_rate),
        .clr       (clr),
        .ce_out    (ce_out),
        .sig_out   (sig_out)
    );

    int            n_tests  = 0;
    int            n_fail   = 0;
    int            gap      = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] last_exp = '0;

    typedef struct {
        logic [3:0]    rate;
        int            n;
        logic [DW-1:0] smp [8];
        logic [DW-1:0] exp_t;   // truncated mean
        logic [DW-1:0] exp_r;   // rounded half-up mean
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock of stimulus followed by the per-cycle output check.
    task automatic step(input bit ce, input logic [DW-1:0] smp, input bit c,
                        input bit has_exp, input logic [DW-1:0] e);
        ce_in  = ce;
        sig_in = smp;
        clr    = c;
        if (has_exp) exp_q.push_back(e);
        @(posedge clk);
        #1;
        ce_in = 1'b0;
        clr   = 1'b0;
        if (ce_out || exp_q.size() != 0) begin
            n_tests++;
            if (!ce_out) begin
                n_fail++;
                $display("FAIL ce_out_latency: got ce_out=0 expected 1 (mean %h pending)",
                         exp_q[0]);
                void'(exp_q.pop_front());
            end else if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL ce_out_spurious: got ce_out=1 sig_out=%h expected ce_out=0",
                         sig_out);
            end else begin
                last_exp = exp_q.pop_front();
                if (sig_out !== last_exp) begin
                    n_fail++;
                    $display("FAIL mean: got %h expected %h", sig_out, last_exp);
                end
            end
        end else begin
            check("sig_out_hold", sig_out, last_exp);
        end
    endtask

    task automatic sample(input logic [DW-1:0] smp, input bit has_exp,
                          input logic [DW-1:0] e);
        step(1'b1, smp, 1'b0, has_exp, e);
        for (int g = 0; g < gap; g++) step(1'b0, '0, 1'b0, 1'b0, '0);
    endtask

    function automatic logic [DW-1:0] pick(input logic [DW-1:0] t,
                                           input logic [DW-1:0] r);
`ifdef ROUND_EN
        return r;
`else
        return t;
`endif
    endfunction

    initial begin
        #10ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{4'd2, 4, '{16'd1, 16'd2, 16'd3, 16'd5, 16'd0, 16'd0, 16'd0, 16'd0},
                    16'd2, 16'd3};
        vecs[1] = '{4'd1, 2, '{16'hFFFD, 16'hFFFE, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0},
                    16'hFFFD, 16'hFFFE};
        vecs[2] = '{4'd0, 1, '{16'd7, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0},
                    16'd7, 16'd7};
        vecs[3] = '{4'd0, 1, '{16'h8000, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0},
                    16'h8000, 16'h8000};
        vecs[4] = '{4'd3, 8, '{16'd100, 16'd100, 16'd100, 16'd100, 16'd100, 16'd100, 16'd100, 16'd100},
                    16'd100, 16'd100};
        vecs[5] = '{4'd2, 4, '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'd0, 16'd0, 16'd0, 16'd0},
                    16'h7FFF, 16'h7FFF};
        vecs[6] = '{4'd2, 4, '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'd0, 16'd0, 16'd0, 16'd0},
                    16'h8000, 16'h8000};
        vecs[7] = '{4'd1, 2, '{16'd4, 16'hFFFF, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0},
                    16'd1, 16'd2};
        vecs[8] = '{4'd3, 8, '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8},
                    16'd4, 16'd5};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_ce_out", {15'b0, ce_out}, 16'd0);
        check("reset_sig_out", sig_out, 16'd0);
        rst_n = 1'b1;

        // Table vectors: back-to-back ce_in, then sparse (1 in 7 cycles)
        for (int pass = 0; pass < 2; pass++) begin
            gap = (pass == 0) ? 0 : 6;
            for (int i = 0; i < 9; i++) begin
                log2_rate = vecs[i].rate;
                for (int j = 0; j < vecs[i].n; j++)
                    sample(vecs[i].smp[j], (j == vecs[i].n - 1),
                           pick(vecs[i].exp_t, vecs[i].exp_r));
            end
        end
        gap = 0;

        // Reset mid-block: 5 of 8 samples accumulated are discarded
        log2_rate = 4'd3;
        for (int j = 0; j < 5; j++) sample(16'd50, 1'b0, '0);
        rst_n = 1'b0;
        #1;
        check("midreset_ce_out", {15'b0, ce_out}, 16'd0);
        check("midreset_sig_out", sig_out, 16'd0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        last_exp = '0;
        for (int j = 0; j < 8; j++) sample(16'd100, (j == 7), 16'd100);

        // Ratio change mid-block is ignored until the block ends
        log2_rate = 4'd2;
        sample(16'd4, 1'b0, '0);
        sample(16'd8, 1'b0, '0);
        log2_rate = 4'd0;
        sample(16'd12, 1'b0, '0);
        sample(16'd16, 1'b1, 16'd10);
        sample(16'd5, 1'b1, 16'd5);
        sample(16'hFFFA, 1'b1, 16'hFFFA);

        // Clamp: 15 requested, ML=8 -> 256 samples, sum of 0..255 = 32640
        log2_rate = 4'd15;
        for (int j = 0; j < 256; j++)
            sample(DW'(j), (j == 255), pick(16'd127, 16'd128));

        // clr coincident with the 3rd ce_in discards the partial block
        log2_rate = 4'd2;
        sample(16'd9, 1'b0, '0);
        sample(16'd9, 1'b0, '0);
        step(1'b1, 16'd9, 1'b1, 1'b0, '0);
        for (int j = 0; j < 4; j++) sample(16'h7FFF, (j == 3), 16'h7FFF);
        for (int j = 0; j < 4; j++) sample(16'h8000, (j == 3), 16'h8000);

        repeat (3) step(1'b0, '0, 1'b0, 1'b0, '0);
        check("queue_drained", DW'(exp_q.size()), 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
